// File: rtl/rob_alloc_ctrl_pkg.sv
// ============================================================================
// Module   : rob_alloc_ctrl_pkg
// Purpose  : Shared ROB allocation types, sizes and state encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rob_alloc_ctrl_pkg;

    localparam int ROB_SIZE_DEF     = 64;
    localparam int ROB_SIZE_LOG_DEF = 6;

    localparam logic [1:0] ROB_STATE_IDLE = 2'b00;
    localparam logic [1:0] ROB_STATE_WALK = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = ROB_STATE_IDLE,
        ST_WALK = ROB_STATE_WALK
    } rob_state_e;

    typedef struct packed {
        logic                        flag;
        logic [ROB_SIZE_LOG_DEF-1:0] idx;
    } robptr_t;

endpackage

`default_nettype wire

// File: rtl/rob_alloc_ctrl_robptr_add.sv
// ============================================================================
// Module   : robptr_add
// Purpose  : Combinational {flag,idx} pointer add/sub modulo 2*ROB_SIZE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module robptr_add #(
    parameter int W = 7
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_y
);

    // The flag is the MSB, so plain modular arithmetic toggles it on wrap.
    always_comb begin
        o_y = i_sub ? (i_a - i_b) : (i_a + i_b);
    end

endmodule

`default_nettype wire

// File: rtl/rob_alloc_ctrl.sv
// ============================================================================
// Module   : rob_alloc_ctrl
// Purpose  : Dual-wide ROB allocator with flush rollback and squash walk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_alloc_ctrl
    import rob_alloc_ctrl_pkg::*;
#(
    parameter int ROB_SIZE     = ROB_SIZE_DEF,
    parameter int ROB_SIZE_LOG = ROB_SIZE_LOG_DEF
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    disp0_valid,
    input  logic                    disp1_valid,
    input  logic                    issue_ready,
    output logic                    disp0_ready,
    output logic                    disp1_ready,
    output logic                    disp0_robidx_flag,
    output logic [ROB_SIZE_LOG-1:0] disp0_robidx,
    output logic                    disp1_robidx_flag,
    output logic [ROB_SIZE_LOG-1:0] disp1_robidx,
    input  logic                    commit0_valid,
    input  logic                    commit1_valid,
    input  logic                    flush_valid,
    input  logic                    flush_robidx_flag,
    input  logic [ROB_SIZE_LOG-1:0] flush_robidx,
    output logic [ROB_SIZE_LOG:0]   counter,
    output logic                    enq_robidx_flag,
    output logic [ROB_SIZE_LOG-1:0] enq_robidx,
    output logic                    deq_robidx_flag,
    output logic [ROB_SIZE_LOG-1:0] deq_robidx,
    output logic [1:0]              rob_state,
    output logic                    walk0_valid,
    output logic [ROB_SIZE_LOG-1:0] walk0_robidx,
    output logic                    walk1_valid,
    output logic [ROB_SIZE_LOG-1:0] walk1_robidx
);

    localparam int            PW     = ROB_SIZE_LOG + 1;
    localparam logic [PW:0]   C_FULL = (PW+1)'(ROB_SIZE);
    localparam logic [PW-1:0] C_ONE  = PW'(1);
    localparam logic [PW-1:0] C_TWO  = PW'(2);

    rob_state_e    state_q, state_d;
    logic [PW-1:0] enq_q, enq_d;
    logic [PW-1:0] deq_q, deq_d;
    logic [PW-1:0] walk_q, walk_d;
    logic [PW-1:0] cnt_q, cnt_d;

    logic          w_base, w_fire0, w_fire1, w_in_walk, w_walk0, w_walk1;
    logic [PW:0]   w_cnt_ext;
    logic [PW-1:0] w_fire_cnt, w_commit_cnt, w_walk_cnt, w_flush_ptr;
    logic [PW-1:0] w_enq_p1, w_enq_adv, w_deq_nx, w_flush_p1, w_flush_cnt;
    logic [PW-1:0] w_walk_m1, w_walk_m2, w_walk_nx;

    assign w_cnt_ext    = {1'b0, cnt_q};
    assign w_base       = (state_q == ST_IDLE) & ~flush_valid & issue_ready;
    assign disp0_ready  = w_base & (w_cnt_ext < C_FULL);
    assign disp1_ready  = w_base & disp0_valid & ((w_cnt_ext + (PW+1)'(2)) <= C_FULL);
    assign w_fire0      = disp0_valid & disp0_ready;
    assign w_fire1      = disp1_valid & disp1_ready;
    assign w_fire_cnt   = PW'(w_fire0) + PW'(w_fire1);
    assign w_commit_cnt = PW'(commit0_valid) + PW'(commit1_valid);
    assign w_flush_ptr  = {flush_robidx_flag, flush_robidx};

    assign w_in_walk  = (state_q == ST_WALK);
    assign w_walk0    = w_in_walk & (walk_q != enq_q);
    assign w_walk1    = w_walk0 & (w_walk_m1 != enq_q);
    assign w_walk_cnt = PW'(w_walk0) + PW'(w_walk1);

    robptr_add #(.W(PW)) u_enq_p1 (
        .i_a(enq_q), .i_b(C_ONE), .i_sub(1'b0), .o_y(w_enq_p1)
    );
    robptr_add #(.W(PW)) u_enq_adv (
        .i_a(enq_q), .i_b(w_fire_cnt), .i_sub(1'b0), .o_y(w_enq_adv)
    );
    robptr_add #(.W(PW)) u_deq_adv (
        .i_a(deq_q), .i_b(w_commit_cnt), .i_sub(1'b0), .o_y(w_deq_nx)
    );
    robptr_add #(.W(PW)) u_flush_p1 (
        .i_a(w_flush_ptr), .i_b(C_ONE), .i_sub(1'b0), .o_y(w_flush_p1)
    );
    // Occupancy after a flush is the distance from the post-commit head to the new tail.
    robptr_add #(.W(PW)) u_flush_dist (
        .i_a(w_flush_p1), .i_b(w_deq_nx), .i_sub(1'b1), .o_y(w_flush_cnt)
    );
    robptr_add #(.W(PW)) u_walk_m1 (
        .i_a(walk_q), .i_b(C_ONE), .i_sub(1'b1), .o_y(w_walk_m1)
    );
    robptr_add #(.W(PW)) u_walk_m2 (
        .i_a(walk_q), .i_b(C_TWO), .i_sub(1'b1), .o_y(w_walk_m2)
    );
    robptr_add #(.W(PW)) u_walk_adv (
        .i_a(walk_q), .i_b(w_walk_cnt), .i_sub(1'b1), .o_y(w_walk_nx)
    );

    always_comb begin
        state_d = state_q;
        enq_d   = enq_q;
        deq_d   = w_deq_nx;
        walk_d  = walk_q;
        cnt_d   = cnt_q + w_fire_cnt - w_commit_cnt;
        if (flush_valid) begin
            enq_d = w_flush_p1;
            cnt_d = w_flush_cnt;
            // A second flush mid-walk only pulls the stop point back; walk_ptr holds.
            if ((state_q == ST_IDLE) && (enq_q != w_flush_p1)) begin
                walk_d  = enq_q;
                state_d = ST_WALK;
            end
        end else if (state_q == ST_WALK) begin
            walk_d = w_walk_nx;
            if (w_walk_nx == enq_q) begin
                state_d = ST_IDLE;
            end
        end else begin
            enq_d = w_enq_adv;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            enq_q   <= '0;
            deq_q   <= '0;
            walk_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            enq_q   <= enq_d;
            deq_q   <= deq_d;
            walk_q  <= walk_d;
            cnt_q   <= cnt_d;
        end
    end

    assign disp0_robidx_flag = enq_q[PW-1];
    assign disp0_robidx      = enq_q[PW-2:0];
    assign disp1_robidx_flag = w_enq_p1[PW-1];
    assign disp1_robidx      = w_enq_p1[PW-2:0];
    assign counter           = cnt_q;
    assign enq_robidx_flag   = enq_q[PW-1];
    assign enq_robidx        = enq_q[PW-2:0];
    assign deq_robidx_flag   = deq_q[PW-1];
    assign deq_robidx        = deq_q[PW-2:0];
    assign rob_state         = state_q;
    assign walk0_valid       = w_walk0;
    assign walk1_valid       = w_walk1;
    assign walk0_robidx      = w_in_walk ? w_walk_m1[PW-2:0] : '0;
    assign walk1_robidx      = w_in_walk ? w_walk_m2[PW-2:0] : '0;

    a_commit0_empty: assert property (@(posedge clock) disable iff (!reset_n)
        !(commit0_valid && (cnt_q == '0)));
    a_commit1_alone: assert property (@(posedge clock) disable iff (!reset_n)
        !(commit1_valid && !commit0_valid));
    a_commit1_low: assert property (@(posedge clock) disable iff (!reset_n)
        !(commit1_valid && (cnt_q < C_TWO)));
    a_cnt_range: assert property (@(posedge clock) disable iff (!reset_n)
        w_cnt_ext <= C_FULL);
    // In-flight entries span [deq, enq), and that span is exactly cnt_q long.
    a_flush_range: assert property (@(posedge clock) disable iff (!reset_n)
        flush_valid |-> (PW'(w_flush_ptr - deq_q) < cnt_q));

endmodule

`default_nettype wire

// File: tb/tb_rob_alloc_ctrl.sv
// ============================================================================
// Module   : tb_rob_alloc_ctrl
// Purpose  : Directed self-checking bench for rob_alloc_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rob_alloc_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       disp0_valid = 1'b0, disp1_valid = 1'b0, issue_ready = 1'b0;
    logic       disp0_ready, disp1_ready;
    logic       disp0_robidx_flag, disp1_robidx_flag;
    logic [5:0] disp0_robidx, disp1_robidx;
    logic       commit0_valid = 1'b0, commit1_valid = 1'b0;
    logic       flush_valid = 1'b0, flush_robidx_flag = 1'b0;
    logic [5:0] flush_robidx = '0;
    logic [6:0] counter;
    logic       enq_robidx_flag, deq_robidx_flag;
    logic [5:0] enq_robidx, deq_robidx;
    logic [1:0] rob_state;
    logic       walk0_valid, walk1_valid;
    logic [5:0] walk0_robidx, walk1_robidx;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    rob_alloc_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .disp0_valid(disp0_valid), .disp1_valid(disp1_valid), .issue_ready(issue_ready),
        .disp0_ready(disp0_ready), .disp1_ready(disp1_ready),
        .disp0_robidx_flag(disp0_robidx_flag), .disp0_robidx(disp0_robidx),
        .disp1_robidx_flag(disp1_robidx_flag), .disp1_robidx(disp1_robidx),
        .commit0_valid(commit0_valid), .commit1_valid(commit1_valid),
        .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag),
        .flush_robidx(flush_robidx), .counter(counter),
        .enq_robidx_flag(enq_robidx_flag), .enq_robidx(enq_robidx),
        .deq_robidx_flag(deq_robidx_flag), .deq_robidx(deq_robidx),
        .rob_state(rob_state),
        .walk0_valid(walk0_valid), .walk0_robidx(walk0_robidx),
        .walk1_valid(walk1_valid), .walk1_robidx(walk1_robidx)
    );

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        disp0_valid = 0; disp1_valid = 0; issue_ready = 0;
        commit0_valid = 0; commit1_valid = 0; flush_valid = 0;
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
    endtask

    task automatic fill_pairs(input int n);
        disp0_valid = 1; disp1_valid = 1; issue_ready = 1;
        repeat (n) cyc();
        disp0_valid = 0; disp1_valid = 0;
    endtask

    task automatic commit_pairs(input int n);
        commit0_valid = 1; commit1_valid = 1;
        repeat (n) cyc();
        commit0_valid = 0; commit1_valid = 0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        checks++;
        if ({counter, enq_robidx_flag, enq_robidx, deq_robidx_flag, deq_robidx} !== 21'd0) begin
            errors++; $display("FAIL reset_ptrs: got cnt=%0d enq=%0d deq=%0d required 0", counter, enq_robidx, deq_robidx);
        end
        checks++;
        if ({rob_state, walk0_valid, walk1_valid, disp0_ready, disp1_ready} !== 6'd0) begin
            errors++; $display("FAIL reset_ctrl: got st=%0d w=%b%b rdy=%b%b required 0", rob_state, walk0_valid, walk1_valid, disp0_ready, disp1_ready);
        end
    endtask

    task automatic test_dispatch;
        do_reset();
        disp0_valid = 1; disp1_valid = 1; issue_ready = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({disp0_ready, disp1_ready, disp0_robidx_flag, disp0_robidx, disp1_robidx_flag, disp1_robidx}
                !== {2'b11, 1'b0, 6'(2*c), 1'b0, 6'(2*c+1)}) begin
                errors++; $display("FAIL dispatch_grant%0d: got rdy=%b%b idx=%0d/%0d required 11 %0d/%0d",
                    c, disp0_ready, disp1_ready, disp0_robidx, disp1_robidx, 2*c, 2*c+1);
            end
            cyc();
        end
        disp0_valid = 0; disp1_valid = 0;
        checks++;
        if (counter !== 7'd6) begin
            errors++; $display("FAIL dispatch_counter: got %0d required 6", counter);
        end
    endtask

    task automatic test_full;
        do_reset();
        fill_pairs(31);
        disp0_valid = 1; cyc(); disp0_valid = 0;
        checks++;
        if (counter !== 7'd63) begin
            errors++; $display("FAIL full_cnt63: got %0d required 63", counter);
        end
        disp0_valid = 1; disp1_valid = 1;
        #1;
        checks++;
        if ({disp0_ready, disp1_ready} !== 2'b10) begin
            errors++; $display("FAIL full_ready63: got %b%b required 10", disp0_ready, disp1_ready);
        end
        cyc();
        checks++;
        if ({counter, disp0_ready} !== {7'd64, 1'b0}) begin
            errors++; $display("FAIL full_cnt64: got cnt=%0d rdy0=%b required 64/0", counter, disp0_ready);
        end
        checks++;
        if ({enq_robidx_flag, enq_robidx, deq_robidx_flag, deq_robidx} !== {7'h40, 7'h00}) begin
            errors++; $display("FAIL full_ptrs: got enq=%b:%0d deq=%b:%0d required 1:0 0:0", enq_robidx_flag, enq_robidx, deq_robidx_flag, deq_robidx);
        end
        commit0_valid = 1;
        cyc();
        commit0_valid = 0;
        checks++;
        if ({counter, disp0_ready} !== {7'd63, 1'b1}) begin
            errors++; $display("FAIL full_commit: got cnt=%0d rdy0=%b required 63/1", counter, disp0_ready);
        end
        disp0_valid = 0; disp1_valid = 0;
    endtask

    task automatic test_wrap;
        do_reset();
        fill_pairs(30);
        commit_pairs(30);
        checks++;
        if ({counter, enq_robidx_flag, enq_robidx, deq_robidx_flag, deq_robidx} !== {7'd0, 7'd60, 7'd60}) begin
            errors++; $display("FAIL wrap_setup: got cnt=%0d enq=%0d deq=%0d required 0/60/60", counter, enq_robidx, deq_robidx);
        end
        fill_pairs(3);
        checks++;
        if ({counter, enq_robidx_flag, enq_robidx} !== {7'd6, 1'b1, 6'd2}) begin
            errors++; $display("FAIL wrap_enq: got cnt=%0d enq=%b:%0d required 6 1:2", counter, enq_robidx_flag, enq_robidx);
        end
        commit_pairs(3);
        checks++;
        if ({counter, deq_robidx_flag, deq_robidx} !== {7'd0, 1'b1, 6'd2}) begin
            errors++; $display("FAIL wrap_deq: got cnt=%0d deq=%b:%0d required 0 1:2", counter, deq_robidx_flag, deq_robidx);
        end
    endtask

    task automatic start_flush(input logic [5:0] idx);
        flush_valid = 1; flush_robidx_flag = 0; flush_robidx = idx;
        cyc();
        flush_valid = 0;
    endtask

    task automatic test_flush_walk;
        do_reset();
        fill_pairs(5);
        start_flush(6'd4);
        checks++;
        if ({enq_robidx, counter, rob_state} !== {6'd5, 7'd5, 2'b01}) begin
            errors++; $display("FAIL flush_state: got enq=%0d cnt=%0d st=%0d required 5/5/1", enq_robidx, counter, rob_state);
        end
        checks++;
        if ({walk0_valid, walk0_robidx, walk1_valid, walk1_robidx, disp0_ready} !== {1'b1, 6'd9, 1'b1, 6'd8, 1'b0}) begin
            errors++; $display("FAIL walk_pair0: got %b:%0d %b:%0d rdy=%b required 1:9 1:8 0", walk0_valid, walk0_robidx, walk1_valid, walk1_robidx, disp0_ready);
        end
        cyc();
        checks++;
        if ({walk0_valid, walk0_robidx, walk1_valid, walk1_robidx, disp0_ready} !== {1'b1, 6'd7, 1'b1, 6'd6, 1'b0}) begin
            errors++; $display("FAIL walk_pair1: got %b:%0d %b:%0d rdy=%b required 1:7 1:6 0", walk0_valid, walk0_robidx, walk1_valid, walk1_robidx, disp0_ready);
        end
        cyc();
        checks++;
        if ({walk0_valid, walk0_robidx, walk1_valid, rob_state, disp0_ready} !== {1'b1, 6'd5, 1'b0, 2'b01, 1'b0}) begin
            errors++; $display("FAIL walk_last: got %b:%0d w1=%b st=%0d rdy=%b required 1:5 0 1 0", walk0_valid, walk0_robidx, walk1_valid, rob_state, disp0_ready);
        end
        cyc();
        checks++;
        if ({rob_state, walk0_valid, walk1_valid, disp0_ready} !== {2'b00, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL walk_done: got st=%0d w=%b%b rdy=%b required 0 00 1", rob_state, walk0_valid, walk1_valid, disp0_ready);
        end
    endtask

    task automatic test_nested_flush;
        do_reset();
        fill_pairs(5);
        start_flush(6'd4);
        cyc();
        start_flush(6'd2);
        checks++;
        if ({enq_robidx, counter, rob_state} !== {6'd3, 7'd3, 2'b01}) begin
            errors++; $display("FAIL nest_state: got enq=%0d cnt=%0d st=%0d required 3/3/1", enq_robidx, counter, rob_state);
        end
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({walk0_valid, walk0_robidx, walk1_valid, walk1_robidx} !== {1'b1, 6'(7-2*p), 1'b1, 6'(6-2*p)}) begin
                errors++; $display("FAIL nest_pair%0d: got %b:%0d %b:%0d required 1:%0d 1:%0d", p, walk0_valid, walk0_robidx, walk1_valid, walk1_robidx, 7-2*p, 6-2*p);
            end
            cyc();
        end
        checks++;
        if ({walk0_valid, walk0_robidx, walk1_valid} !== {1'b1, 6'd3, 1'b0}) begin
            errors++; $display("FAIL nest_last: got %b:%0d w1=%b required 1:3 0", walk0_valid, walk0_robidx, walk1_valid);
        end
        cyc();
        checks++;
        if (rob_state !== 2'b00) begin
            errors++; $display("FAIL nest_done: got st=%0d required 0", rob_state);
        end
    endtask

    task automatic test_flush_edges;
        do_reset();
        fill_pairs(5);
        start_flush(6'd9);
        checks++;
        if ({rob_state, counter, enq_robidx, walk0_valid} !== {2'b00, 7'd10, 6'd10, 1'b0}) begin
            errors++; $display("FAIL flush_nowalk: got st=%0d cnt=%0d enq=%0d w0=%b required 0/10/10/0", rob_state, counter, enq_robidx, walk0_valid);
        end
        do_reset();
        fill_pairs(5);
        commit0_valid = 1; commit1_valid = 1;
        start_flush(6'd9);
        commit0_valid = 0; commit1_valid = 0;
        checks++;
        if ({deq_robidx, counter, rob_state} !== {6'd2, 7'd8, 2'b00}) begin
            errors++; $display("FAIL flush_commit: got deq=%0d cnt=%0d st=%0d required 2/8/0", deq_robidx, counter, rob_state);
        end
        do_reset();
        fill_pairs(5);
        start_flush(6'd4);
        checks++;
        if (rob_state !== 2'b01) begin
            errors++; $display("FAIL areset_pre: got st=%0d required 1", rob_state);
        end
        issue_ready = 0;
        #2 reset_n = 0;
        #1;
        checks++;
        if ({rob_state, walk0_valid, walk1_valid, walk0_robidx, walk1_robidx, counter, enq_robidx, deq_robidx, disp0_ready, disp1_ready} !== '0) begin
            errors++; $display("FAIL areset_walk: got st=%0d w=%b%b cnt=%0d enq=%0d deq=%0d required all 0", rob_state, walk0_valid, walk1_valid, counter, enq_robidx, deq_robidx);
        end
        cyc();
        reset_n = 1;
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_full();
        test_wrap();
        test_flush_walk();
        test_nested_flush();
        test_flush_edges();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
